// File: rtl/vx_sched_perf_pkg.sv
// Shared types and widths for the scheduler performance counter block.
package vx_sched_perf_pkg;

    localparam int unsigned NUM_WARPS_DEF = 4;
    localparam int unsigned PERF_CTR_BITS = 44;
    localparam int unsigned SCHED_CNT_W   = $clog2(NUM_WARPS_DEF + 1);

    // One sampled cycle of scheduler status, carried through the stage-1 register.
    typedef struct packed {
        logic                   en;
        logic                   idle;
        logic                   stall;
        logic [SCHED_CNT_W-1:0] act_cnt;
        logic [SCHED_CNT_W-1:0] stl_cnt;
    } sched_perf_sample_t;

endpackage

// File: rtl/vx_sched_perf_popcount.sv
// Combinational population count of an N-bit vector.
module vx_sched_perf_popcount #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]               in_i,
    output logic [$clog2(N+1)-1:0]     cnt_o
);

    localparam int unsigned OUT_W = $clog2(N + 1);

    logic [OUT_W-1:0] cnt;

    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cnt = cnt + OUT_W'(in_i[i]);
        end
    end

    assign cnt_o = cnt;

endmodule

// File: rtl/vx_sched_perf.sv
// Scheduler performance counters: idles, stalls, stalled and active warp sums.
// Status is sampled into a stage-1 register, then accumulated one cycle later.
module vx_sched_perf
    import vx_sched_perf_pkg::*;
#(
    parameter int unsigned NUM_WARPS = NUM_WARPS_DEF,
    parameter int unsigned CTR_W     = PERF_CTR_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 perf_en,
    input  logic                 schedule_valid,
    input  logic                 schedule_ready,
    input  logic [NUM_WARPS-1:0] active_mask,
    input  logic [NUM_WARPS-1:0] stalled_mask,
    output logic [CTR_W-1:0]     sched_idles,
    output logic [CTR_W-1:0]     sched_stalls,
    output logic [CTR_W-1:0]     stalled_warps,
    output logic [CTR_W-1:0]     active_warps
);

    localparam int unsigned CNT_W = $clog2(NUM_WARPS + 1);

    logic [CNT_W-1:0]   act_cnt;
    logic [CNT_W-1:0]   stl_cnt;
    logic [NUM_WARPS-1:0] stl_active;

    sched_perf_sample_t sample_d, sample_q;

    logic [CTR_W-1:0] idles_d,  idles_q;
    logic [CTR_W-1:0] stalls_d, stalls_q;
    logic [CTR_W-1:0] stlw_d,   stlw_q;
    logic [CTR_W-1:0] actw_d,   actw_q;

    // Stalled bits of inactive warps never count.
    assign stl_active = stalled_mask & active_mask;

    vx_sched_perf_popcount #(.N(NUM_WARPS)) u_pop_act (
        .in_i  (active_mask),
        .cnt_o (act_cnt)
    );

    vx_sched_perf_popcount #(.N(NUM_WARPS)) u_pop_stl (
        .in_i  (stl_active),
        .cnt_o (stl_cnt)
    );

    always_comb begin
        sample_d         = '0;
        sample_d.en      = perf_en;
        sample_d.idle    = ~schedule_valid;
        sample_d.stall   = schedule_valid & ~schedule_ready;
        sample_d.act_cnt = SCHED_CNT_W'(act_cnt);
        sample_d.stl_cnt = SCHED_CNT_W'(stl_cnt);
    end

    // Enable travels with its sample, so gating applies to exactly that cycle.
    always_comb begin
        idles_d  = idles_q;
        stalls_d = stalls_q;
        stlw_d   = stlw_q;
        actw_d   = actw_q;
        if (sample_q.en) begin
            idles_d  = idles_q  + CTR_W'(sample_q.idle);
            stalls_d = stalls_q + CTR_W'(sample_q.stall);
            stlw_d   = stlw_q   + CTR_W'(sample_q.stl_cnt);
            actw_d   = actw_q   + CTR_W'(sample_q.act_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q <= '0;
            idles_q  <= '0;
            stalls_q <= '0;
            stlw_q   <= '0;
            actw_q   <= '0;
        end else begin
            sample_q <= sample_d;
            idles_q  <= idles_d;
            stalls_q <= stalls_d;
            stlw_q   <= stlw_d;
            actw_q   <= actw_d;
        end
    end

    assign sched_idles   = idles_q;
    assign sched_stalls  = stalls_q;
    assign stalled_warps = stlw_q;
    assign active_warps  = actw_q;

endmodule

// File: tb/tb_vx_sched_perf.sv
// Directed, table-driven bench for vx_sched_perf (NUM_WARPS=4, CTR_W=8).
module tb_vx_sched_perf;

    localparam int unsigned NW = 4;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          perf_en;
    logic          schedule_valid;
    logic          schedule_ready;
    logic [NW-1:0] active_mask;
    logic [NW-1:0] stalled_mask;
    logic [CW-1:0] sched_idles;
    logic [CW-1:0] sched_stalls;
    logic [CW-1:0] stalled_warps;
    logic [CW-1:0] active_warps;

    int errors = 0;
    int checks = 0;

    vx_sched_perf #(.NUM_WARPS(NW), .CTR_W(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .perf_en        (perf_en),
        .schedule_valid (schedule_valid),
        .schedule_ready (schedule_ready),
        .active_mask    (active_mask),
        .stalled_mask   (stalled_mask),
        .sched_idles    (sched_idles),
        .sched_stalls   (sched_stalls),
        .stalled_warps  (stalled_warps),
        .active_warps   (active_warps)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic          v;
        logic          r;
        logic [NW-1:0] am;
        logic [NW-1:0] sm;
        int            ncyc;
        int            e_idle;
        int            e_stall;
        int            e_stl;
        int            e_act;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [CW-1:0] got, input int exp);
        checks++;
        if (got !== CW'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, CW'(exp));
        end
    endtask

    task automatic chk_all(input string name, input int ei, input int es, input int ew, input int ea);
        chk({name, ".idles"},  sched_idles,   ei);
        chk({name, ".stalls"}, sched_stalls,  es);
        chk({name, ".stlw"},   stalled_warps, ew);
        chk({name, ".actw"},   active_warps,  ea);
    endtask

    // Advance to the next cycle and drive that cycle's inputs.
    task automatic cyc(input logic rst, input logic en, input logic v, input logic r,
                       input logic [NW-1:0] am, input logic [NW-1:0] sm);
        @(posedge clk);
        #1;
        reset          = rst;
        perf_en        = en;
        schedule_valid = v;
        schedule_ready = r;
        active_mask    = am;
        stalled_mask   = sm;
    endtask

    // Three reset cycles with busy inputs; outputs must already be zero.
    task automatic do_reset();
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 4'hF);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 4'hF);
        chk_all("reset", 0, 0, 0, 0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 4'hF);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; perf_en = 1'b0; schedule_valid = 1'b0; schedule_ready = 1'b0;
        active_mask = '0; stalled_mask = '0;

        //          en    v     r     am       sm       n  idl stl stw act
        vecs[0] = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 10, 10, 0,  0,  0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 4,  0,  4,  0,  0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 4'b1011, 4'b0110, 5,  0,  0,  5,  15};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 4'b1111, 4'b1111, 3,  0,  3,  12, 12};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111, 5,  0,  0,  0,  0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b1111, 4,  4,  0,  0,  0};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 4'b0001, 4'b0001, 7,  0,  0,  7,  7};

        for (int k = 0; k < 7; k++) begin
            do_reset();
            for (int i = 0; i < vecs[k].ncyc; i++)
                cyc(1'b0, vecs[k].en, vecs[k].v, vecs[k].r, vecs[k].am, vecs[k].sm);
            cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 4'hF);
            cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 4'hF);
            chk_all($sformatf("vec%0d", k), vecs[k].e_idle, vecs[k].e_stall,
                    vecs[k].e_stl, vecs[k].e_act);
        end

        // Stalls followed by accepted issues.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        chk("stall_issue.stalls", sched_stalls, 4);
        chk("stall_issue.idles",  sched_idles,  0);

        // Enable gating: en 1,1,1,0,0,0,1,1 then 0; valid low throughout.
        do_reset();
        begin
            logic [9:0] en_pat;
            int exp_idle [10];
            en_pat = 10'b0011000111;
            exp_idle = '{0, 0, 1, 2, 3, 3, 3, 3, 4, 5};
            for (int c = 0; c < 10; c++) begin
                cyc(1'b0, en_pat[c], 1'b0, 1'b0, 4'h0, 4'h0);
                if (c >= 1) chk($sformatf("gate.c%0d", c), sched_idles, exp_idle[c]);
            end
        end

        // Wrap: all-ones active mask, 64 samples at 4 per cycle.
        do_reset();
        for (int c = 0; c < 64; c++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 4'h0);
            if (c == 33) chk("wrap.mid", active_warps, 128);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 4'h0);
        chk("wrap.252", active_warps, 252);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 4'h0);
        chk("wrap.zero", active_warps, 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 4'h0);
        chk("wrap.hold", active_warps, 0);

        // Reset while a busy sample sits in stage 1.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 4'hF);
        chk("midrst.pre.idles", sched_idles, 2);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 4'hF);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        chk_all("midrst.after", 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
            chk_all($sformatf("midrst.rel%0d", i), 0, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vx_sched_perf.md
Name: vx_sched_perf

Overview:
- Producer of the scheduler performance counters: sched_idles, sched_stalls, stalled_warps and active_warps.
- Sits inside the scheduler under PERF_ENABLE. It samples per-cycle scheduler status and accumulates it into PERF_CTR_BITS-wide running counters.
- Its four counter outputs drive the schedule modport of VX_pipeline_perf_if directly.
- Popcounts are pipelined one stage for timing.

Parameters:
- NUM_WARPS, default `NUM_WARPS, warps per core; width of the status masks.
- CTR_W, default `PERF_CTR_BITS, width of every counter output.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- perf_en  in  1  accumulate enable; 0 freezes all counters.
- schedule_valid  in  1  scheduler presents a warp this cycle.
- schedule_ready  in  1  downstream (ibuffer/fetch) accepts it.
- active_mask  in  NUM_WARPS  warps currently active.
- stalled_mask  in  NUM_WARPS  warps currently stalled.
- sched_idles  out  CTR_W  cycles with no warp scheduled.
- sched_stalls  out  CTR_W  cycles with a warp offered but not accepted.
- stalled_warps  out  CTR_W  running sum of stalled active warps per cycle.
- active_warps  out  CTR_W  running sum of active warps per cycle.

Behaviour:
- Interface: one clock (clk), reset is synchronous and active-high (reset).
- Stage 0 (combinational on the cycle-N inputs):
  - idle_evt = ~schedule_valid.
  - stall_evt = schedule_valid & ~schedule_ready.
  - act_cnt = popcount(active_mask).
  - stl_cnt = popcount(stalled_mask & active_mask). Stalled bits for inactive warps are ignored.
  - act_cnt and stl_cnt are each $clog2(NUM_WARPS+1) bits wide.
- Stage 1 register (edge ending cycle N):
  - Holds {en = perf_en, idle_evt, stall_evt, act_cnt, stl_cnt}.
  - perf_en travels with its event, so gating is exact per sampled cycle.
- Counter update (edge ending cycle N+1), only when the stage-1 en is set:
  - sched_idles += idle_evt.
  - sched_stalls += stall_evt.
  - active_warps += act_cnt.
  - stalled_warps += stl_cnt.
- Latency: an input in cycle N is visible on the outputs in cycle N+2. Throughput is one sample per cycle with no backpressure.
- Arithmetic:
  - Unsigned; increments are zero-extended to CTR_W.
  - Counters wrap modulo 2^CTR_W with no saturation and no sticky overflow flag.
- Mutually exclusive events: idle_evt and stall_evt never assert together. The accepted-issue case (valid & ready) increments neither.
- Reset:
  - All four outputs and all stage-1 fields read 0 in the cycle after reset is sampled high.
  - Stage-1 en is cleared, so in-flight samples are discarded.
  - The first sample after release (cycle R) appears on the outputs in cycle R+2.
- perf_en toggling: counters hold their value exactly while the sampled en = 0. No clear-on-disable.
- Mask corner cases:
  - active_mask = 0 adds 0 to active_warps and stalled_warps.
  - All ones adds NUM_WARPS.
- X-safety: the outputs depend only on registered state. No combinational input-to-output path.

Decomposition:
- Shared package (VX_gpu_pkg):
  - PERF_CTR_BITS usage.
  - A localparam for the warp-count width, $clog2(NUM_WARPS+1).
  - A packed struct sched_perf_sample_t {en, idle, stall, act_cnt, stl_cnt} for the stage-1 register.
- Sub-module: one popcount instance per mask, reusing the existing VX_popcount (N = NUM_WARPS).
- No other sub-modules. The counters and the pipeline register stay in this block.

Test Plan:
- Reset then idle:
  - Stimulus: reset 3 cycles, then schedule_valid=0, masks 0, perf_en=1 for 10 cycles.
  - Response: sched_idles=10 two cycles after the last sample; the other three counters stay 0.
- Stall vs issue:
  - Stimulus: 4 cycles valid=1/ready=0, then 6 cycles valid=1/ready=1.
  - Response: sched_stalls=4, sched_idles=0.
- Masking, NUM_WARPS=4:
  - Stimulus: active=4'b1011, stalled=4'b0110 held for 5 cycles.
  - Response: active_warps=15, stalled_warps=5 (only bit1 counts per cycle).
- Enable gating and latency:
  - Stimulus: perf_en=1 for cycles 0-2, 0 for cycles 3-5, 1 for cycles 6-7, with valid=0 throughout.
  - Response:
    - sched_idles first reads 1 in cycle 2.
    - Holds 3 during cycles 5-7.
    - Reads 5 in cycle 9.
- Wrap-around, CTR_W forced to 8:
  - Stimulus: all-ones active mask with NUM_WARPS=4 for 64 cycles.
  - Response: active_warps wraps 252 -> 0 and then reads 0 (256 mod 256).
- Reset mid-operation:
  - Stimulus: reset asserted one cycle after a busy sample, i.e. while that sample is in stage 1.
  - Response:
    - All outputs read 0 in the cycle after reset is sampled.
    - The discarded sample never appears after release.
